// File: rtl/multi_counter_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_counter_dispatcher                                      |
// | Description : Customers (number + service time) arrive on a valid strobe.   |
// |               Each one is sent to the lowest-index free service counter or  |
// |               waits in a FIFO. It is dropped if the FIFO is full. One        |
// |               dispatch per clock.                                           |
// | Option      : DISPATCH_STATS_EN adds saturating served/drop counters.       |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module multi_counter_dispatcher #(
    parameter int NUM_CNT    = 3,
    parameter int FIFO_DEPTH = 3,
    parameter int NUM_W      = 4,
    parameter int TIME_W     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [NUM_W-1:0]                     in_num,
    input  logic [TIME_W-1:0]                    in_time,
    output logic [NUM_CNT*NUM_W-1:0]             cnt_num,
    output logic [NUM_CNT*TIME_W-1:0]            cnt_rem,
    output logic [NUM_CNT-1:0]                   cnt_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      q_count,
    output logic                                 q_full,
    output logic                                 q_empty,
    output logic                                 drop,
`ifdef DISPATCH_STATS_EN
    output logic [15:0]                          served_cnt,
    output logic [15:0]                          drop_cnt,
`endif
    output logic [FIFO_DEPTH*(NUM_W+TIME_W)-1:0] qdbg
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int EW = NUM_W + TIME_W;
    localparam logic [CW-1:0] c_depth = CW'(FIFO_DEPTH);

    // Counter state
    logic [NUM_W-1:0]  r_num [NUM_CNT];
    logic [TIME_W-1:0] r_rem [NUM_CNT];

    // Queue is kept head-aligned: slot 0 is always the oldest entry and
    // unused slots hold zero. The observable order is the same as that of a
    // wrapping ring buffer, and no re-indexing is needed for the debug view.
    logic [NUM_W-1:0]  r_q_num  [FIFO_DEPTH];
    logic [TIME_W-1:0] r_q_time [FIFO_DEPTH];
    logic [CW-1:0]     r_count;
    logic              r_drop;

    logic [NUM_CNT-1:0] w_free;
    logic [NUM_CNT-1:0] w_grant;
    logic               w_any_free;
    logic               w_arrive;
    logic               w_q_nonempty;
    logic               w_pop;
    logic               w_bypass;
    logic               w_dispatch;
    logic               w_push;
    logic               w_drop;
    logic [NUM_W-1:0]   w_load_num;
    logic [TIME_W-1:0]  w_load_time;
    logic [CW-1:0]      w_push_idx;
    logic [CW-1:0]      w_count_nxt;
    logic [NUM_W-1:0]   w_q_num_nxt  [FIFO_DEPTH];
    logic [TIME_W-1:0]  w_q_time_nxt [FIFO_DEPTH];

    // Dispatch decision, made from state sampled before the edge
    always_comb begin
        w_any_free   = |w_free;
        // Isolate the lowest set bit: the lowest-index free counter wins
        w_grant      = w_free & (~w_free + NUM_CNT'(1));
        w_arrive     = in_valid && (in_time != '0);
        w_q_nonempty = (r_count != '0);
        w_pop        = w_any_free && w_q_nonempty;
        w_bypass     = w_any_free && !w_q_nonempty && w_arrive;
        w_dispatch   = w_pop || w_bypass;
        // A pop on the same edge always frees a slot, even in a full queue
        w_push       = w_arrive && !w_bypass && (w_pop || (r_count != c_depth));
        w_drop       = w_arrive && !w_bypass && !w_push;
        w_load_num   = w_pop ? r_q_num[0]  : in_num;
        w_load_time  = w_pop ? r_q_time[0] : in_time;
        w_push_idx   = w_pop ? (r_count - CW'(1)) : r_count;
        w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Next queue contents: shift toward the head on pop, then write the arrival at the tail
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_q_num_nxt[i]  = r_q_num[i];
            w_q_time_nxt[i] = r_q_time[i];
        end
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH-1; i++) begin
                w_q_num_nxt[i]  = r_q_num[i+1];
                w_q_time_nxt[i] = r_q_time[i+1];
            end
            w_q_num_nxt[FIFO_DEPTH-1]  = '0;
            w_q_time_nxt[FIFO_DEPTH-1] = '0;
        end
        if (w_push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) == w_push_idx) begin
                    w_q_num_nxt[i]  = in_num;
                    w_q_time_nxt[i] = in_time;
                end
            end
        end
    end

    // Queue storage, occupancy and drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_num[i]  <= '0;
                r_q_time[i] <= '0;
            end
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_num[i]  <= w_q_num_nxt[i];
                r_q_time[i] <= w_q_time_nxt[i];
            end
            r_count <= w_count_nxt;
            r_drop  <= w_drop;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
            assign w_free[i]                  = (r_rem[i] == '0);
            assign cnt_busy[i]                = ~w_free[i];
            assign cnt_num[i*NUM_W +: NUM_W]   = r_num[i];
            assign cnt_rem[i*TIME_W +: TIME_W] = r_rem[i];

            // Load on grant, otherwise count down; the number clears as rem reaches zero
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_num[i] <= '0;
                    r_rem[i] <= '0;
                end else if (w_dispatch && w_grant[i]) begin
                    r_num[i] <= w_load_num;
                    r_rem[i] <= w_load_time;
                end else if (r_rem[i] != '0) begin
                    r_rem[i] <= r_rem[i] - TIME_W'(1);
                    if (r_rem[i] == TIME_W'(1)) begin
                        r_num[i] <= '0;
                    end
                end
            end
        end

        for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_qdbg
            assign qdbg[i*EW +: EW] = {r_q_num[i], r_q_time[i]};
        end
    endgenerate

    assign q_count = r_count;
    assign q_full  = (r_count == c_depth);
    assign q_empty = (r_count == '0);
    assign drop    = r_drop;

`ifdef DISPATCH_STATS_EN
    logic [15:0] r_served;
    logic [15:0] r_drops;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_served <= '0;
            r_drops  <= '0;
        end else begin
            if (w_dispatch && (r_served != 16'hFFFF)) begin
                r_served <= r_served + 16'd1;
            end
            if (w_drop && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
        end
    end

    assign served_cnt = r_served;
    assign drop_cnt   = r_drops;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_counter_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multi_counter_dispatcher                                   |
// | Description : Directed and random stimulus. The outputs are compared with a |
// |               queue-based reference model of the dispatcher.                |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_multi_counter_dispatcher;

    localparam int NUM_CNT    = 3;
    localparam int FIFO_DEPTH = 3;
    localparam int NUM_W      = 4;
    localparam int TIME_W     = 4;
    localparam int QCW        = $clog2(FIFO_DEPTH+1);
    localparam int EW         = NUM_W + TIME_W;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             in_valid;
    logic [NUM_W-1:0]                 in_num;
    logic [TIME_W-1:0]                in_time;
    logic [NUM_CNT*NUM_W-1:0]         cnt_num;
    logic [NUM_CNT*TIME_W-1:0]        cnt_rem;
    logic [NUM_CNT-1:0]               cnt_busy;
    logic [QCW-1:0]                   q_count;
    logic                             q_full;
    logic                             q_empty;
    logic                             drop;
    logic [FIFO_DEPTH*EW-1:0]         qdbg;
`ifdef DISPATCH_STATS_EN
    logic [15:0]                      served_cnt;
    logic [15:0]                      drop_cnt;
`endif

    multi_counter_dispatcher #(
        .NUM_CNT(NUM_CNT), .FIFO_DEPTH(FIFO_DEPTH), .NUM_W(NUM_W), .TIME_W(TIME_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_num(in_num), .in_time(in_time),
        .cnt_num(cnt_num), .cnt_rem(cnt_rem), .cnt_busy(cnt_busy), .q_count(q_count),
        .q_full(q_full), .q_empty(q_empty), .drop(drop),
`ifdef DISPATCH_STATS_EN
        .served_cnt(served_cnt), .drop_cnt(drop_cnt),
`endif
        .qdbg(qdbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_num [NUM_CNT];
    int m_rem [NUM_CNT];
    int q_num [$];
    int q_time [$];
    int m_drop;
    int m_served;
    int m_drops;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the dispatcher, from the rules rather than the circuit
    task automatic model_edge(input logic r, input logic v, input int n, input int t);
        int f;
        if (r) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                m_num[i] = 0;
                m_rem[i] = 0;
            end
            q_num.delete();
            q_time.delete();
            m_drop   = 0;
            m_served = 0;
            m_drops  = 0;
            return;
        end
        f = -1;
        for (int i = NUM_CNT-1; i >= 0; i--) if (m_rem[i] == 0) f = i;
        m_drop = 0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_num[i] = 0;
            end
        end
        if (f >= 0 && q_num.size() > 0) begin
            m_num[f] = q_num.pop_front();
            m_rem[f] = q_time.pop_front();
            m_served++;
            if (v && t != 0) begin
                q_num.push_back(n);
                q_time.push_back(t);
            end
        end else if (v && t != 0) begin
            if (f >= 0) begin
                m_num[f] = n;
                m_rem[f] = t;
                m_served++;
            end else if (q_num.size() < FIFO_DEPTH) begin
                q_num.push_back(n);
                q_time.push_back(t);
            end else begin
                m_drop = 1;
                m_drops++;
            end
        end
    endtask

    task automatic check_all();
        logic [NUM_CNT*NUM_W-1:0]  e_num;
        logic [NUM_CNT*TIME_W-1:0] e_rem;
        logic [NUM_CNT-1:0]        e_busy;
        logic [FIFO_DEPTH*EW-1:0]  e_q;
        e_num  = '0;
        e_rem  = '0;
        e_busy = '0;
        e_q    = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            e_num[i*NUM_W +: NUM_W]   = NUM_W'(m_num[i]);
            e_rem[i*TIME_W +: TIME_W] = TIME_W'(m_rem[i]);
            e_busy[i]                 = (m_rem[i] != 0);
        end
        for (int i = 0; i < q_num.size(); i++) begin
            e_q[i*EW +: EW] = {NUM_W'(q_num[i]), TIME_W'(q_time[i])};
        end
        check_value("cnt_num",  64'(cnt_num),  64'(e_num));
        check_value("cnt_rem",  64'(cnt_rem),  64'(e_rem));
        check_value("cnt_busy", 64'(cnt_busy), 64'(e_busy));
        check_value("q_count",  64'(q_count),  64'(q_num.size()));
        check_value("q_full",   64'(q_full),   64'(q_num.size() == FIFO_DEPTH));
        check_value("q_empty",  64'(q_empty),  64'(q_num.size() == 0));
        check_value("drop",     64'(drop),     64'(m_drop));
        check_value("qdbg",     64'(qdbg),     64'(e_q));
`ifdef DISPATCH_STATS_EN
        check_value("served_cnt", 64'(served_cnt), 64'(m_served));
        check_value("drop_cnt",   64'(drop_cnt),   64'(m_drops));
`endif
    endtask

    task automatic step(input logic r, input logic v, input int n, input int t);
        rst      = r;
        in_valid = v;
        in_num   = n[NUM_W-1:0];
        in_time  = t[TIME_W-1:0];
        @(posedge clk);
        model_edge(r, v, n, t);
        #1;
        check_all();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_num   = 4'd9;
        in_time  = 4'd3;

        // Reset held two cycles with a live arrival
        step(1'b1, 1'b1, 9, 3);
        step(1'b1, 1'b1, 9, 3);
        check_value("rst_q_empty", 64'(q_empty), 64'd1);
        check_value("rst_cnt_rem", 64'(cnt_rem), 64'd0);

        // Fill all counters, then the queue, then overflow
        step(1'b0, 1'b1, 1, 8);
        step(1'b0, 1'b1, 2, 8);
        step(1'b0, 1'b1, 3, 8);
        check_value("load_num", 64'(cnt_num), 64'h321);
        step(1'b0, 1'b1, 4, 1);
        step(1'b0, 1'b1, 5, 5);
        step(1'b0, 1'b1, 6, 2);
        check_value("full_qdbg", 64'(qdbg), 64'h625541);
        check_value("full_flag", 64'(q_full), 64'd1);
        step(1'b0, 1'b1, 7, 3);
        check_value("drop_pulse", 64'(drop), 64'd1);
        check_value("drop_qdbg", 64'(qdbg), 64'h625541);
        step(1'b0, 1'b0, 0, 0);
        check_value("drop_once", 64'(drop), 64'd0);
`ifdef DISPATCH_STATS_EN
        check_value("stats_served", 64'(served_cnt), 64'd3);
        check_value("stats_drops",  64'(drop_cnt),   64'd1);
`endif
        // Zero service time is ignored
        step(1'b0, 1'b1, 8, 0);
        // Drain the queue and counters
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 0, 0);
        check_value("drain_empty", 64'(q_empty), 64'd1);

        // Reset in mid-service
        step(1'b0, 1'b1, 10, 9);
        step(1'b0, 1'b1, 11, 9);
        step(1'b1, 1'b1, 12, 9);
        check_value("midrst_busy", 64'(cnt_busy), 64'd0);

        // Random traffic with heavy load and occasional resets
        for (int k = 0; k < 3000; k++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 399) == 0);
            v = ($urandom_range(0, 99) < 70);
            step(r, v, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
